// File: rtl/refill_writer.sv
// Cache line refill engine: takes one set request, streams an 8-beat critical-word-first
// burst into the banked SRAM write port, forwards the critical word and flags read conflicts.
module refill_writer #(
  parameter int SET_W  = 7,
  parameter int WORDS  = 8,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [SET_W-1:0]           req_set,
  input  logic [$clog2(WORDS)-1:0]   req_word,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [DATA_W-1:0]          mem_data,
  input  logic                       mem_last,
  output logic                       sram_w_en,
  output logic [SET_W-1:0]           sram_w_addr,
  output logic [DATA_W-1:0]          sram_w_data,
  output logic [WORDS-1:0]           sram_w_maskOH,
  output logic                       crit_valid,
  output logic [DATA_W-1:0]          crit_data,
  input  logic [SET_W-1:0]           rd_set,
  output logic                       rd_conflict,
  output logic                       resp_valid,
  output logic [SET_W-1:0]           resp_set,
  output logic                       resp_err
);
  localparam int PTR_W = $clog2(WORDS);
  localparam int CNT_W = $clog2(WORDS + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]       state;
  logic [SET_W-1:0] cur_set;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic             beat_acc;
  logic             first_beat;
  logic             last_beat;
  logic [PTR_W-1:0] bank;
  logic [WORDS-1:0] mask_nxt;

  assign req_ready  = (state == S_IDLE);
  assign mem_ready  = (state == S_REFILL) && (cnt < CNT_W'(WORDS));
  assign beat_acc   = mem_valid && mem_ready;
  assign first_beat = (cnt == '0);
  assign last_beat  = (cnt == CNT_W'(WORDS - 1));
  // Bank index wraps naturally in PTR_W bits.
  assign bank       = ptr + cnt[PTR_W-1:0];

  for (genvar b = 0; b < WORDS; b++) begin : g_mask
    assign mask_nxt[b] = (bank == PTR_W'(b));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cur_set <= '0;
      ptr     <= '0;
      cnt     <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          cur_set <= req_set;
          ptr     <= req_word;
          cnt     <= '0;
          err     <= 1'b0;
          state   <= S_REFILL;
        end
        S_REFILL: if (beat_acc) begin
          cnt <= cnt + 1'b1;
          // mem_last is only checked; the burst always ends on count.
          if (last_beat ? !mem_last : mem_last) err <= 1'b1;
          if (last_beat) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_w_en     <= 1'b0;
      sram_w_addr   <= '0;
      sram_w_data   <= '0;
      sram_w_maskOH <= '0;
      crit_valid    <= 1'b0;
      crit_data     <= '0;
    end else begin
      sram_w_en     <= beat_acc;
      sram_w_maskOH <= beat_acc ? mask_nxt : '0;
      crit_valid    <= beat_acc && first_beat;
      if (beat_acc) begin
        sram_w_addr <= cur_set;
        sram_w_data <= mem_data;
      end
      if (beat_acc && first_beat) crit_data <= mem_data;
    end
  end

  assign resp_valid  = (state == S_RESP);
  assign resp_set    = cur_set;
  assign resp_err    = resp_valid && err;
  assign rd_conflict = (state != S_IDLE) && (rd_set == cur_set);
endmodule

// File: tb/tb_refill_writer.sv
// Directed bench for refill_writer: stimulus pushes expected writes/crit/resp into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_refill_writer;
  localparam int SET_W = 7, WORDS = 8, DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready;
  logic [SET_W-1:0]  req_set;
  logic [2:0]        req_word;
  logic              mem_valid, mem_ready, mem_last;
  logic [DATA_W-1:0] mem_data;
  logic              sram_w_en;
  logic [SET_W-1:0]  sram_w_addr;
  logic [DATA_W-1:0] sram_w_data;
  logic [WORDS-1:0]  sram_w_maskOH;
  logic              crit_valid;
  logic [DATA_W-1:0] crit_data;
  logic [SET_W-1:0]  rd_set;
  logic              rd_conflict, resp_valid, resp_err;
  logic [SET_W-1:0]  resp_set;

  refill_writer #(.SET_W(SET_W), .WORDS(WORDS), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set), .req_word(req_word),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_data(mem_data), .mem_last(mem_last),
    .sram_w_en(sram_w_en), .sram_w_addr(sram_w_addr), .sram_w_data(sram_w_data),
    .sram_w_maskOH(sram_w_maskOH), .crit_valid(crit_valid), .crit_data(crit_data),
    .rd_set(rd_set), .rd_conflict(rd_conflict),
    .resp_valid(resp_valid), .resp_set(resp_set), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [SET_W-1:0] addr; logic [WORDS-1:0] mask; logic [DATA_W-1:0] data;} wr_t;
  typedef struct packed {logic [SET_W-1:0] set; logic err;} rsp_t;

  wr_t               wr_q[$];
  logic [DATA_W-1:0] crit_q[$];
  rsp_t              rsp_q[$];
  int errors = 0;
  int checks = 0;
  logic acc_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got unexpected/absent event expected scoreboard match", name);
  endtask

  // Monitor: every write must land exactly one cycle after its acceptance.
  always @(negedge clk) begin
    wr_t  e;
    rsp_t r;
    logic [DATA_W-1:0] c;
    if (!rst_n) acc_prev = 1'b0;
    else begin
      chk("w_en_latency", sram_w_en, acc_prev);
      if (sram_w_en) begin
        if (wr_q.size() == 0) miss("spurious_write");
        else begin
          e = wr_q.pop_front();
          chk("w_addr", sram_w_addr, e.addr);
          chk("w_mask", sram_w_maskOH, e.mask);
          chk("w_data", sram_w_data, e.data);
        end
      end else chk("w_mask_idle", sram_w_maskOH, 0);
      if (crit_valid) begin
        if (crit_q.size() == 0) miss("spurious_crit");
        else begin
          c = crit_q.pop_front();
          chk("crit_data", crit_data, c);
        end
      end
      if (resp_valid) begin
        if (rsp_q.size() == 0) miss("spurious_resp");
        else begin
          r = rsp_q.pop_front();
          chk("resp_set", resp_set, r.set);
          chk("resp_err", resp_err, r.err);
        end
      end
      acc_prev = mem_valid && mem_ready;
    end
  end

  // One refill: gap idle cycles between beats, mem_last on beat last_at (-1 = never).
  task automatic send_line(input logic [SET_W-1:0] set, input logic [2:0] word,
                           input logic [DATA_W-1:0] base, input int gap, input int last_at,
                           input logic exp_err, input int n_beats,
                           input logic [SET_W-1:0] rset, input logic exp_conf);
    int t;
    logic [2:0] b;
    rd_set = rset;
    t = 0;
    while (!req_ready && t < 50) begin @(posedge clk); #1; t++; end
    chk("req_ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_set = set; req_word = word;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("req_ready_refill", req_ready, 0);
    chk("conflict_refill", rd_conflict, exp_conf);
    for (int k = 0; k < n_beats; k++) begin
      if (k > 0) for (int g = 0; g < gap; g++) begin
        mem_valid = 1'b0; @(posedge clk); #1;
      end
      mem_valid = 1'b1;
      mem_data  = base + DATA_W'(k);
      mem_last  = (k == last_at);
      t = 0;
      while (!mem_ready && t < 50) begin @(posedge clk); #1; t++; end
      if (!mem_ready) begin miss("mem_ready_timeout"); break; end
      b = word + 3'(k);
      wr_q.push_back('{set, 8'd1 << b, base + DATA_W'(k)});
      if (k == 0) crit_q.push_back(base);
      if (k == WORDS - 1) rsp_q.push_back('{set, exp_err});
      @(posedge clk); #1;
    end
    mem_last = 1'b0;
    if (n_beats == WORDS) begin
      // RESP cycle: a 9th beat is offered and must be refused.
      mem_data = base + 32'h8;
      chk("mem_ready_9th", mem_ready, 0);
      chk("resp_valid_now", resp_valid, 1);
      chk("conflict_resp", rd_conflict, exp_conf);
      @(posedge clk); #1;
      mem_valid = 1'b0;
      chk("mem_ready_idle", mem_ready, 0);
      chk("req_ready_idle", req_ready, 1);
      chk("conflict_idle", rd_conflict, 0);
    end else mem_valid = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_mem_ready"}, mem_ready, 0);
    chk({tag, "_w_en"}, sram_w_en, 0);
    chk({tag, "_w_addr"}, sram_w_addr, 0);
    chk({tag, "_w_data"}, sram_w_data, 0);
    chk({tag, "_w_mask"}, sram_w_maskOH, 0);
    chk({tag, "_crit_valid"}, crit_valid, 0);
    chk({tag, "_crit_data"}, crit_data, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_set"}, resp_set, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_conflict"}, rd_conflict, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_set = '0; req_word = '0;
    mem_valid = 1'b0; mem_data = '0; mem_last = 1'b0; rd_set = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("por");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic, wrap, back-pressure, framing (early last / missing last), conflict
    send_line(7'h15, 3'd0, 32'hA0, 0, 7,  1'b0, 8, 7'h15, 1'b1);
    send_line(7'h22, 3'd6, 32'hB0, 0, 7,  1'b0, 8, 7'h22, 1'b1);
    send_line(7'h33, 3'd3, 32'hC0, 2, 7,  1'b0, 8, 7'h00, 1'b0);
    send_line(7'h05, 3'd1, 32'hD0, 0, 3,  1'b1, 8, 7'h05, 1'b1);
    send_line(7'h06, 3'd2, 32'hE0, 1, -1, 1'b1, 8, 7'h06, 1'b1);
    send_line(7'h40, 3'd5, 32'hF0, 0, 7,  1'b0, 8, 7'h40, 1'b1);
    send_line(7'h40, 3'd4, 32'h100, 0, 7, 1'b0, 8, 7'h41, 1'b0);

    // Reset mid-burst after beat 4
    send_line(7'h2A, 3'd7, 32'h200, 0, 7, 1'b0, 5, 7'h33, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("midrst");
    chk("midrst_wr_q_empty", wr_q.size(), 0);
    chk("midrst_crit_q_empty", crit_q.size(), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    send_line(7'h2A, 3'd7, 32'h300, 0, 7, 1'b0, 8, 7'h2A, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    chk("end_wr_q_empty", wr_q.size(), 0);
    chk("end_crit_q_empty", crit_q.size(), 0);
    chk("end_rsp_q_empty", rsp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
